alu_arbiter: RTL and testbench

Shares the single 32-bit ALU between two requesters: requester 0 is the core execute path and requester 1 is the address/debug unit. Arbitration is round-robin, and each requester has a valid/ready request channel and a valid/ready response channel. The ALU operation completes combinationally inside the block, and the result is registered and held until the winning requester accepts it. The block sits between the decode/issue logic and the ALU and owns the ALU's operand and control inputs.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu.sv | 34 +++
 rtl/alu_arbiter.sv | 149 ++++++++++++++
 tb/tb_alu_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, arbiter state encoding and the
// opcode legality check used to flag unsupported operations.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0101;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_RESP = 1'b1
    } arb_state_e;

    // True for the opcodes the ALU implements; everything else is reported as err.
    function automatic logic alu_op_valid(input logic [3:0] op);
        logic ok;
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLL: ok = 1'b1;
            default:                                    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit ALU. Unsupported opcodes yield a zero result,
// so the zero flag is set for them as well.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_src_a,
    input  logic [WIDTH-1:0] i_src_b,
    input  logic [3:0]       i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero
);

    logic [4:0] w_shamt;

    assign w_shamt = i_src_b[4:0];

    // Opcode decode; arithmetic wraps modulo 2^WIDTH, shift uses only the low 5 bits of B.
    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD: o_result = i_src_a + i_src_b;
            ALU_SUB: o_result = i_src_a - i_src_b;
            ALU_AND: o_result = i_src_a & i_src_b;
            ALU_OR:  o_result = i_src_a | i_src_b;
            ALU_SLL: o_result = i_src_a << w_shamt;
            default: o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between the core execute path (0) and
// the address/debug unit (1). The result is registered and held for the
// winning requester until it takes it.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   ARB_IDLE | no result held; one request may be accepted
//   ARB_RESP | result held for r_owner until its rsp_ready
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req_valid_0,
    output logic             req_ready_0,
    input  logic [WIDTH-1:0] req_srcA_0,
    input  logic [WIDTH-1:0] req_srcB_0,
    input  logic [3:0]       req_op_0,

    input  logic             req_valid_1,
    output logic             req_ready_1,
    input  logic [WIDTH-1:0] req_srcA_1,
    input  logic [WIDTH-1:0] req_srcB_1,
    input  logic [3:0]       req_op_1,

    output logic             rsp_valid_0,
    input  logic             rsp_ready_0,
    output logic             rsp_valid_1,
    input  logic             rsp_ready_1,

    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic             busy
);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic             r_prio;
    logic             r_owner;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_err;

    logic             w_grant;
    logic             w_accept;
    logic             w_rsp_take;
    logic [WIDTH-1:0] w_alu_a;
    logic [WIDTH-1:0] w_alu_b;
    logic [3:0]       w_alu_op;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_zero;

    // Grant: the sole valid requester, or the priority holder on a tie.
    always_comb begin
        w_grant = 1'b0;
        if (req_valid_0 && req_valid_1) begin
            w_grant = r_prio;
        end else if (req_valid_1) begin
            w_grant = 1'b1;
        end
    end

    // Operand/opcode mux in front of the single ALU instance.
    always_comb begin
        w_alu_a  = req_srcA_0;
        w_alu_b  = req_srcB_0;
        w_alu_op = req_op_0;
        if (w_grant) begin
            w_alu_a  = req_srcA_1;
            w_alu_b  = req_srcB_1;
            w_alu_op = req_op_1;
        end
    end

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_src_a  (w_alu_a),
        .i_src_b  (w_alu_b),
        .i_op     (w_alu_op),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero)
    );

    // Next state and request handshake; readys are only ever raised in IDLE,
    // so a request that shows up during RESP simply waits.
    always_comb begin
        w_state_nxt = r_state;
        req_ready_0 = 1'b0;
        req_ready_1 = 1'b0;
        w_accept    = 1'b0;
        w_rsp_take  = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                req_ready_0 = req_valid_0 && !w_grant;
                req_ready_1 = req_valid_1 && w_grant;
                w_accept    = req_valid_0 || req_valid_1;
                if (w_accept) begin
                    w_state_nxt = ARB_RESP;
                end
            end
            ARB_RESP: begin
                w_rsp_take = r_owner ? rsp_ready_1 : rsp_ready_0;
                if (w_rsp_take) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // State register; reset drops any held response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture result, flags, owner and rotate priority on an accepted request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prio   <= 1'b0;
            r_owner  <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_owner  <= w_grant;
            r_prio   <= ~w_grant;
            r_result <= w_alu_result;
            r_zero   <= w_alu_zero;
            r_err    <= ~alu_op_valid(w_alu_op);
        end
    end

    assign busy        = (r_state == ARB_RESP);
    assign rsp_valid_0 = busy && !r_owner;
    assign rsp_valid_1 = busy && r_owner;
    assign rsp_result  = r_result;
    assign rsp_zero    = r_zero;
    assign rsp_err     = r_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        v0, v1, rr0, rr1;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  op0, op1;
    logic        req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_err, busy;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: is a response held, for whom, who wins a tie, what is held
    logic        m_known = 1'b0;
    logic        m_show  = 1'b0;
    logic        m_busy  = 1'b0;
    logic        m_owner = 1'b0;
    logic        m_prio  = 1'b0;
    logic [31:0] m_res   = '0;
    logic        m_zero  = 1'b0;
    logic        m_err   = 1'b0;
    logic        e_r0, e_r1, acc0, acc1;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_0 (v0),
        .req_ready_0 (req_ready_0),
        .req_srcA_0  (a0),
        .req_srcB_0  (b0),
        .req_op_0    (op0),
        .req_valid_1 (v1),
        .req_ready_1 (req_ready_1),
        .req_srcA_1  (a1),
        .req_srcB_1  (b1),
        .req_op_1    (op1),
        .rsp_valid_0 (rsp_valid_0),
        .rsp_ready_0 (rr0),
        .rsp_valid_1 (rsp_valid_1),
        .rsp_ready_1 (rr1),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_err     (rsp_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {err, zero, result} straight from the opcode table
    function automatic logic [33:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        logic        e;
        logic [4:0]  sh;
        r  = '0;
        e  = 1'b0;
        sh = b[4:0];
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd5:    r = a << sh;
            default: e = 1'b1;
        endcase
        return {e, (r == 32'd0), r};
    endfunction

    // One clock: check outputs against the model, take the edge, advance the model.
    task automatic tick();
        logic [33:0] x;
        #1;
        e_r0 = !m_busy && v0 && (!v1 || (m_prio == 1'b0));
        e_r1 = !m_busy && v1 && (!v0 || (m_prio == 1'b1));
        if (m_known) begin
            check_eq("req_ready_0", req_ready_0, e_r0);
            check_eq("req_ready_1", req_ready_1, e_r1);
            check_eq("rsp_valid_0", rsp_valid_0, m_busy && !m_owner);
            check_eq("rsp_valid_1", rsp_valid_1, m_busy && m_owner);
            check_eq("busy", busy, m_busy);
            if (m_busy || m_show) begin
                check_eq("rsp_result", rsp_result, m_res);
                check_eq("rsp_zero", rsp_zero, m_zero);
                check_eq("rsp_err", rsp_err, m_err);
            end
        end
        acc0 = rst_n && e_r0;
        acc1 = rst_n && e_r1;
        @(posedge clk);
        if (!rst_n) begin
            m_known = 1'b1;
            m_show  = 1'b1;
            m_busy  = 1'b0;
            m_owner = 1'b0;
            m_prio  = 1'b0;
            m_res   = '0;
            m_zero  = 1'b0;
            m_err   = 1'b0;
        end else if (acc0 || acc1) begin
            x       = acc1 ? ref_alu(op1, a1, b1) : ref_alu(op0, a0, b0);
            m_res   = x[31:0];
            m_zero  = x[32];
            m_err   = x[33];
            m_owner = acc1;
            m_prio  = !acc1;
            m_busy  = 1'b1;
            m_show  = 1'b0;
        end else if (m_busy && (m_owner ? rr1 : rr0)) begin
            m_busy = 1'b0;
        end
        #1;
    endtask

    task automatic rand_req(output logic [31:0] a, output logic [31:0] b, output logic [3:0] op);
        logic [3:0] legal [5];
        legal = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5};
        op = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 4)] : 4'($urandom_range(0, 15));
        a  = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 7);
        b  = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 7);
    endtask

    initial begin
        int w0, w1;
        logic was0, was1;
        rst_n = 1'b0;
        v0 = 0; v1 = 0; rr0 = 0; rr1 = 0;
        a0 = 0; b0 = 0; op0 = 0; a1 = 0; b1 = 0; op1 = 0;
        tick();
        tick();
        rst_n = 1'b1;

        // ADD 5,7 from requester 0
        v0 = 1; a0 = 5; b0 = 7; op0 = 4'b0000;
        tick();
        check_eq("add_valid0", rsp_valid_0, 1);
        check_eq("add_result", rsp_result, 12);
        check_eq("add_zero", rsp_zero, 0);
        check_eq("add_err", rsp_err, 0);
        v0 = 0; rr0 = 1;
        tick();
        rr0 = 0;

        // SUB 3,3 from requester 1
        v1 = 1; a1 = 3; b1 = 3; op1 = 4'b0001;
        tick();
        check_eq("sub_valid1", rsp_valid_1, 1);
        check_eq("sub_result", rsp_result, 0);
        check_eq("sub_zero", rsp_zero, 1);
        v1 = 0; rr1 = 1;
        tick();
        rr1 = 0;

        // both continuously valid, responses always taken: strict alternation
        v0 = 1; a0 = 32'hF0; b0 = 32'h0F; op0 = 4'b0011;
        v1 = 1; a1 = 32'hFF; b1 = 32'h3C; op1 = 4'b0010;
        rr0 = 1; rr1 = 1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k % 2 == 0) begin
                check_eq("rr_owner0", rsp_valid_0, ((k / 2) % 2) == 0);
                check_eq("rr_result", rsp_result, ((k / 2) % 2 == 0) ? 32'hFF : 32'h3C);
            end else begin
                check_eq("rr_idle", busy, 0);
            end
        end
        v0 = 0; v1 = 0; rr0 = 0; rr1 = 0;

        // backpressure: SLL 1 by 33 (uses 1), requester 1 waits
        v0 = 1; a0 = 1; b0 = 33; op0 = 4'b0101;
        tick();
        v0 = 0;
        v1 = 1; a1 = 10; b1 = 20; op1 = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("bp_result", rsp_result, 2);
            check_eq("bp_busy", busy, 1);
            check_eq("bp_ready1", req_ready_1, 0);
        end
        rr0 = 1;
        tick();
        rr0 = 0;
        tick();
        check_eq("bp_valid1", rsp_valid_1, 1);
        check_eq("bp_result1", rsp_result, 30);
        v1 = 0; rr1 = 1;
        tick();
        rr1 = 0;

        // unsupported opcode
        v0 = 1; a0 = 9; b0 = 9; op0 = 4'b0110;
        tick();
        check_eq("bad_result", rsp_result, 0);
        check_eq("bad_zero", rsp_zero, 1);
        check_eq("bad_err", rsp_err, 1);
        v0 = 0; rr0 = 1;
        tick();
        rr0 = 0;

        // reset while a response is held
        v0 = 1; a0 = 1; b0 = 2; op0 = 4'b0000;
        tick();
        v0 = 0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("rst_valid0", rsp_valid_0, 0);
        check_eq("rst_valid1", rsp_valid_1, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_result", rsp_result, 0);
        check_eq("rst_zero", rsp_zero, 0);
        check_eq("rst_err", rsp_err, 0);
        v0 = 1; a0 = 4; b0 = 4; op0 = 4'b0000;
        v1 = 1; a1 = 9; b1 = 1; op1 = 4'b0001;
        tick();
        check_eq("post_rst_prio0", rsp_valid_0, 1);
        check_eq("post_rst_result", rsp_result, 8);
        v0 = 0; rr0 = 1;
        tick();
        rr0 = 0;
        tick();
        check_eq("post_rst_valid1", rsp_valid_1, 1);
        v1 = 0; rr1 = 1;
        tick();
        rr1 = 0;

        // randomized traffic with occasional reset and a fairness watch
        w0 = 0; w1 = 0;
        for (int c = 0; c < 600; c++) begin
            if (!v0 && $urandom_range(0, 2) != 0) begin
                v0 = 1; rand_req(a0, b0, op0);
            end
            if (!v1 && $urandom_range(0, 2) != 0) begin
                v1 = 1; rand_req(a1, b1, op1);
            end
            rr0   = ($urandom_range(0, 2) != 0);
            rr1   = ($urandom_range(0, 2) != 0);
            rst_n = ($urandom_range(0, 99) != 0);
            was0  = v0;
            was1  = v1;
            tick();
            if (!rst_n) begin
                w0 = 0; w1 = 0;
                rst_n = 1'b1;
            end else begin
                if (acc0) begin
                    check_eq("fair0", (w0 <= 1), 1);
                    w0 = 0; v0 = 0;
                end else if (was0 && acc1) begin
                    w0++;
                end
                if (acc1) begin
                    check_eq("fair1", (w1 <= 1), 1);
                    w1 = 0; v1 = 0;
                end else if (was1 && acc0) begin
                    w1++;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
